// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the ARM operand2 shift sequencer.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        LSL = 2'b00,
        LSR = 2'b01,
        ASR = 2'b10,
        ROR = 2'b11
    } shift_type_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int CNT_W = 6;

endpackage

// File: rtl/shift_amount_decode.sv
// Maps an operand2 shift request onto the number of single-bit steps to run,
// including the immediate-zero special cases (LSR/ASR #32 and RRX).
module shift_amount_decode
    import shift_seq_pkg::*;
(
    input  shift_type_e      shift_type,
    input  logic [7:0]       shift_num,
    input  logic             instr4,
    input  logic             not_shift,
    output logic [CNT_W-1:0] eff,
    output logic             is_rrx
);

    logic       imm_zero;
    logic [7:0] n;

    assign imm_zero = !instr4 && (shift_num[4:0] == 5'd0);
    assign n        = instr4 ? shift_num : {3'b000, shift_num[4:0]};

    // LSL/LSR saturate at 33 steps: enough to push every bit and the carry out.
    always_comb begin
        eff    = '0;
        is_rrx = 1'b0;
        if (!not_shift) begin
            case (shift_type)
                LSL: eff = (n > 8'd33) ? CNT_W'(33) : n[CNT_W-1:0];
                LSR: begin
                    if (imm_zero)
                        eff = CNT_W'(32);
                    else
                        eff = (n > 8'd33) ? CNT_W'(33) : n[CNT_W-1:0];
                end
                ASR: begin
                    if (imm_zero)
                        eff = CNT_W'(32);
                    else
                        eff = (n > 8'd32) ? CNT_W'(32) : n[CNT_W-1:0];
                end
                ROR: begin
                    if (imm_zero) begin
                        eff    = CNT_W'(1);
                        is_rrx = 1'b1;
                    end else if (n == 8'd0)
                        eff = '0;
                    else if (n[4:0] == 5'd0)
                        eff = CNT_W'(32);
                    else
                        eff = {1'b0, n[4:0]};
                end
                default: eff = '0;
            endcase
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle ARM operand2 shifter, BITS_PER_CYCLE steps per clock.
// Define SHIFT_SEQ_PERF_EN to add the perf_ops / perf_stall counters.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1,
    parameter int WIDTH          = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_shift_type,
    input  logic [7:0]       req_shift_num,
    input  logic             req_instr4,
    input  logic             req_not_shift,
    input  logic [WIDTH-1:0] req_x,
    input  logic             req_carry,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_y,
    output logic             resp_c,
    output logic             busy,
    output state_e           dbg_state
`ifdef SHIFT_SEQ_PERF_EN
    ,
    output logic [31:0]      perf_ops,
    output logic [31:0]      perf_stall
`endif
);

    localparam logic [CNT_W-1:0] B_CNT = CNT_W'(BITS_PER_CYCLE);

    state_e            state_q, state_d;
    shift_type_e       type_q, type_d, req_type;
    logic [WIDTH-1:0]  x_q, x_d, sx;
    logic              c_q, c_d, sc, fill;
    logic              rrx_q, rrx_d, dec_rrx;
    logic [CNT_W-1:0]  count_q, count_d, k, dec_eff;

    assign req_type = shift_type_e'(req_shift_type);

    shift_amount_decode u_decode (
        .shift_type (req_type),
        .shift_num  (req_shift_num),
        .instr4     (req_instr4),
        .not_shift  (req_not_shift),
        .eff        (dec_eff),
        .is_rrx     (dec_rrx)
    );

    // Handshakes: a request transfers on a clock edge where req_valid && req_ready,
    // a response on an edge where resp_valid && resp_ready; flush overrides both.
    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign resp_y     = x_q;
    assign resp_c     = c_q;
    assign dbg_state  = state_q;

    // Up to B single-bit steps this cycle; carry ends as the last bit shifted out.
    always_comb begin
        k    = (count_q < B_CNT) ? count_q : B_CNT;
        sx   = x_q;
        sc   = c_q;
        fill = 1'b0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (CNT_W'(i) < k) begin
                case (type_q)
                    LSL: begin
                        sc = sx[WIDTH-1];
                        sx = {sx[WIDTH-2:0], 1'b0};
                    end
                    LSR: begin
                        sc = sx[0];
                        sx = {1'b0, sx[WIDTH-1:1]};
                    end
                    ASR: begin
                        sc = sx[0];
                        sx = {sx[WIDTH-1], sx[WIDTH-1:1]};
                    end
                    default: begin
                        fill = rrx_q ? sc : sx[0];
                        sc   = sx[0];
                        sx   = {fill, sx[WIDTH-1:1]};
                    end
                endcase
            end
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        c_d     = c_q;
        count_d = count_q;
        type_d  = type_q;
        rrx_d   = rrx_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        x_d     = req_x;
                        c_d     = req_carry;
                        count_d = dec_eff;
                        type_d  = req_type;
                        rrx_d   = dec_rrx;
                        state_d = (dec_eff == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    x_d     = sx;
                    c_d     = sc;
                    count_d = count_q - k;
                    if (count_q <= B_CNT)
                        state_d = DONE;
                end
                DONE: begin
                    if (resp_ready)
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            c_q     <= 1'b0;
            count_q <= '0;
            type_q  <= LSL;
            rrx_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            c_q     <= c_d;
            count_q <= count_d;
            type_q  <= type_d;
            rrx_q   <= rrx_d;
        end
    end

`ifdef SHIFT_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_ops   <= '0;
            perf_stall <= '0;
        end else begin
            if (state_q == DONE && resp_ready && !flush)
                perf_ops <= perf_ops + 32'd1;
            if (state_q == SHIFT)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: random and directed operand2 shifts
// against an arithmetic reference model, plus backpressure, flush and reset.
module tb_shift_sequencer;
    import shift_seq_pkg::*;

    localparam int B = 1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_shift_type = 2'b00;
    logic [7:0]  req_shift_num = 8'h00;
    logic        req_instr4 = 1'b0;
    logic        req_not_shift = 1'b0;
    logic [31:0] req_x = 32'h0;
    logic        req_carry = 1'b0;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_y;
    logic        resp_c;
    logic        busy;
    state_e      dbg_state;
`ifdef SHIFT_SEQ_PERF_EN
    logic [31:0] perf_ops, perf_stall;
    logic [31:0] exp_ops = 32'h0, exp_stall = 32'h0;
`endif

    shift_sequencer #(.BITS_PER_CYCLE(B), .WIDTH(32)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .flush          (flush),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_shift_type (req_shift_type),
        .req_shift_num  (req_shift_num),
        .req_instr4     (req_instr4),
        .req_not_shift  (req_not_shift),
        .req_x          (req_x),
        .req_carry      (req_carry),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_y         (resp_y),
        .resp_c         (resp_c),
        .busy           (busy),
        .dbg_state      (dbg_state)
`ifdef SHIFT_SEQ_PERF_EN
        ,
        .perf_ops       (perf_ops),
        .perf_stall     (perf_stall)
`endif
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    logic [32:0] exp_q[$];
    int          lat_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s wait bound expired at cycle %0d", name, cyc);
    endtask

    // ---------------- reference model ----------------
    // Whole-word arithmetic on 64-bit views; the bit just past the result is the carry.
    function automatic void ref_model(input logic [1:0] t, input logic [7:0] num,
                                      input logic i4, input logic ns,
                                      input logic [31:0] x, input logic cin,
                                      output logic [31:0] y, output logic c,
                                      output int steps);
        int          a;
        int          r;
        logic [63:0] t64;
        y = x;
        c = cin;
        steps = 0;
        if (ns) return;
        a = i4 ? int'(num) : int'(num[4:0]);
        case (t)
            2'b00: begin
                steps = (a > 33) ? 33 : a;
                if (a > 32) begin y = 32'h0; c = 1'b0; end
                else if (a > 0) begin
                    t64 = {32'h0, x} << a;
                    y = t64[31:0];
                    c = t64[32];
                end
            end
            2'b01: begin
                if (!i4 && a == 0) a = 32;
                steps = (a > 33) ? 33 : a;
                if (a > 32) begin y = 32'h0; c = 1'b0; end
                else if (a > 0) begin
                    t64 = {x, 32'h0} >> a;
                    y = t64[63:32];
                    c = t64[31];
                end
            end
            2'b10: begin
                if (!i4 && a == 0) a = 32;
                if (a > 32) a = 32;
                steps = a;
                if (a > 0) begin
                    t64 = $signed({x, 32'h0}) >>> a;
                    y = t64[63:32];
                    c = t64[31];
                end
            end
            default: begin
                if (!i4 && a == 0) begin
                    y = {cin, x[31:1]};
                    c = x[0];
                    steps = 1;
                end else if (a > 0) begin
                    r = a % 32;
                    steps = (r == 0) ? 32 : r;
                    t64 = {x, x} >> r;
                    y = t64[31:0];
                    c = y[31];
                end
            end
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_fields(input logic [1:0] t, input logic [7:0] n, input logic i4,
                                input logic ns, input logic [31:0] x, input logic cin);
        req_shift_type = t;
        req_shift_num  = n;
        req_instr4     = i4;
        req_not_shift  = ns;
        req_x          = x;
        req_carry      = cin;
    endtask

    task automatic scramble_fields();
        drive_fields(2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom), 1'($urandom),
                     $urandom, 1'($urandom));
    endtask

    task automatic send(input logic [1:0] t, input logic [7:0] n, input logic i4,
                        input logic ns, input logic [31:0] x, input logic cin);
        logic [31:0] y;
        logic        c;
        int          steps;
        int          budget;
        ref_model(t, n, i4, ns, x, cin, y, c, steps);
        @(negedge clk);
        drive_fields(t, n, i4, ns, x, cin);
        req_valid = 1'b1;
        budget = 0;
        while (!req_ready && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        if (!req_ready) begin
            timeout_fail("accept_timeout");
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        exp_q.push_back({y, c});
        lat_q.push_back(cyc + (1 + (steps + B - 1) / B) - 1);
        req_valid = 1'b0;
        scramble_fields();
    endtask

    // Accept an op without scoreboarding it (it is about to be flushed or reset away).
    task automatic start_raw(input logic [1:0] t, input logic [7:0] n, input logic [31:0] x);
        @(negedge clk);
        drive_fields(t, n, 1'b1, 1'b0, x, 1'b0);
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int b;
        b = 0;
        while ((exp_q.size() != 0 || busy) && b < 500) begin
            @(negedge clk);
            b++;
        end
        if (exp_q.size() != 0 || busy) timeout_fail("drain_timeout");
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic        in_resp = 1'b0;
    int          hold = 0;
    int          force_hold = -1;
    logic [31:0] held_y;
    logic        held_c;
    logic [32:0] mon_e;
    int          mon_l;

    always @(negedge clk) begin
        if (!reset_n) begin
            in_resp    = 1'b0;
            resp_ready = 1'b0;
        end else if (resp_valid) begin
            if (!in_resp) begin
                in_resp = 1'b1;
                held_y  = resp_y;
                held_c  = resp_c;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_resp y=%08h c=%0b, required no response", resp_y, resp_c);
                end else begin
                    mon_e = exp_q.pop_front();
                    mon_l = lat_q.pop_front();
                    chk("resp_y", 64'(resp_y), 64'(mon_e[32:1]));
                    chk("resp_c", 64'(resp_c), 64'(mon_e[0]));
                    chk("latency_cycle", 64'(cyc), 64'(mon_l));
                end
                if (force_hold >= 0) begin
                    hold = force_hold;
                    force_hold = -1;
                end else begin
                    hold = $urandom_range(0, 2);
                end
            end else begin
                chk("hold_stable", 64'({resp_y, resp_c, req_ready}), 64'({held_y, held_c, 1'b0}));
            end
            if (hold > 0) begin
                resp_ready = 1'b0;
                hold--;
            end else begin
                resp_ready = 1'b1;
            end
        end else begin
            in_resp    = 1'b0;
            resp_ready = 1'b0;
        end
    end

`ifdef SHIFT_SEQ_PERF_EN
    always @(posedge clk) begin
        if (!reset_n) begin
            exp_ops   <= 32'h0;
            exp_stall <= 32'h0;
        end else begin
            if (resp_valid && resp_ready && !flush) exp_ops <= exp_ops + 32'd1;
            if (busy && !resp_valid) exp_stall <= exp_stall + 32'd1;
        end
    end
`endif

    task automatic check_reset_values(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'(1));
        chk({tag, "_resp_valid"}, 64'(resp_valid), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_resp_y"}, 64'(resp_y), 64'(0));
        chk({tag, "_resp_c"}, 64'(resp_c), 64'(0));
        chk({tag, "_state"}, 64'(dbg_state), 64'(IDLE));
    endtask

    // ---------------- main sequence ----------------
    logic [7:0] edge_n [6] = '{8'd0, 8'd31, 8'd32, 8'd33, 8'd64, 8'd255};

    initial begin
        int seen;
        logic [7:0] n;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        reset_n = 1'b1;

        // Directed cases and carry-out identities.
        send(LSL, 8'd1,   1'b1, 1'b0, 32'h8000_0001, 1'b0);
        send(LSR, 8'd40,  1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1);
        send(ASR, 8'd0,   1'b0, 1'b0, 32'h8000_0000, 1'b0);
        send(ROR, 8'd32,  1'b1, 1'b0, 32'h8000_0001, 1'b0);
        send(ROR, 8'd0,   1'b0, 1'b0, 32'h0000_0003, 1'b1);
        send(LSR, 8'd7,   1'b1, 1'b1, 32'h1234_5678, 1'b1);
        send(LSL, 8'd32,  1'b1, 1'b0, 32'h0000_0001, 1'b0);
        send(LSL, 8'd33,  1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1);
        send(ASR, 8'd200, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1);
        send(ROR, 8'd0,   1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1);
        send(ROR, 8'd36,  1'b1, 1'b0, 32'hF000_000F, 1'b0);
        send(LSR, 8'hE0,  1'b0, 1'b0, 32'h8000_0000, 1'b0);
        send(LSL, 8'hFF,  1'b0, 1'b0, 32'h0000_0003, 1'b0);
        drain();

        // Backpressure: response held for 5 cycles, then the next request follows.
        force_hold = 5;
        send(ASR, 8'd4, 1'b1, 1'b0, 32'h8765_4321, 1'b0);
        send(LSL, 8'd3, 1'b1, 1'b0, 32'h0000_0011, 1'b1);
        drain();

        // Flush during the third SHIFT cycle of LSL 20.
        start_raw(LSL, 8'd20, 32'h0F0F_0F0F);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("pre_flush_busy", 64'(busy), 64'(1));
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", 64'(busy), 64'(0));
        chk("flush_req_ready", 64'(req_ready), 64'(1));
        chk("flush_state", 64'(dbg_state), 64'(IDLE));
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        chk("flush_no_resp", 64'(seen), 64'(0));

        // Flush wins over a request presented in the same cycle.
        @(negedge clk);
        drive_fields(LSL, 8'd5, 1'b1, 1'b0, 32'h1, 1'b0);
        req_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_prio_busy", 64'(busy), 64'(0));

        // Reset in the middle of an operation.
        start_raw(ASR, 8'd25, 32'h8000_1234);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_values("midop_reset");
        reset_n = 1'b1;

        // Randomized operations.
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 3))
                0:       n = 8'($urandom_range(0, 40));
                1:       n = edge_n[$urandom_range(0, 5)];
                default: n = 8'($urandom);
            endcase
            send(2'($urandom_range(0, 3)), n, 1'($urandom), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 3) == 0) ? 32'h8000_0000 | $urandom : $urandom,
                 1'($urandom));
        end
        drain();

`ifdef SHIFT_SEQ_PERF_EN
        @(negedge clk);
        chk("perf_ops", 64'(perf_ops), 64'(exp_ops));
        chk("perf_stall", 64'(perf_stall), 64'(exp_stall));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
